// File: rtl/video_register_arbiter.sv
// Round-robin arbiter funnelling three one-entry write buffers onto one video register port.
// Optional VIDEO_REG_ARB_COALESCE_EN: same-index requests overwrite a waiting buffered write.
module video_register_arbiter #(
  parameter int MIN_GAP = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req_valid,
  input  logic [11:0] req_index,
  input  logic [68:0] req_value,
  output logic [2:0]  req_ack,
  input  logic        register_busy,
  output logic [3:0]  register_index,
  output logic [22:0] register_value,
  output logic [2:0]  pending,
  output logic [1:0]  dbg_state
);

  // Handshake: a requester holds req_valid with stable index/value until it sees
  // its req_ack pulse, then drops or changes it; valid seen during the ack cycle is ignored.

  localparam logic [3:0] VIDEO_NOP = 4'hF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t      state_q;
  logic [3:0]  out_index_q;
  logic [22:0] out_value_q;
  logic [1:0]  last_grant_q;
  logic [3:0]  gap_cnt_q;

  logic [2:0]  full_q;
  logic [2:0]  ack_q;
  logic [3:0]  buf_index_q [3];
  logic [22:0] buf_value_q [3];

  logic [1:0]  cand0, cand1, cand2;
  logic [1:0]  grant_idx;
  logic        grant_found;
  logic        grant_fire;
  logic [2:0]  capture_new;
  logic [2:0]  coalesce;

  function automatic logic [1:0] rr_next(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign cand0 = rr_next(last_grant_q);
  assign cand1 = rr_next(cand0);
  assign cand2 = rr_next(cand1);

  always_comb begin
    grant_found = 1'b1;
    grant_idx   = cand0;
    if (full_q[cand0]) begin
      grant_idx = cand0;
    end else if (full_q[cand1]) begin
      grant_idx = cand1;
    end else if (full_q[cand2]) begin
      grant_idx = cand2;
    end else begin
      grant_found = 1'b0;
    end
  end

  assign grant_fire = (state_q == IDLE) && !register_busy && grant_found;

  // A buffer being granted this cycle neither captures nor coalesces.
  always_comb begin
    capture_new = '0;
    coalesce    = '0;
    for (int n = 0; n < 3; n++) begin
      capture_new[n] = req_valid[n] && !ack_q[n] && !full_q[n];
`ifdef VIDEO_REG_ARB_COALESCE_EN
      coalesce[n] = req_valid[n] && !ack_q[n] && full_q[n]
                    && (req_index[4*n +: 4] == buf_index_q[n])
                    && !(grant_fire && (grant_idx == 2'(n)));
`else
      coalesce[n] = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= '0;
      ack_q  <= '0;
      for (int n = 0; n < 3; n++) begin
        buf_index_q[n] <= '0;
        buf_value_q[n] <= '0;
      end
    end else begin
      for (int n = 0; n < 3; n++) begin
        ack_q[n] <= 1'b0;
        if (grant_fire && (grant_idx == 2'(n))) begin
          full_q[n] <= 1'b0;
        end else if (capture_new[n]) begin
          full_q[n]      <= 1'b1;
          ack_q[n]       <= 1'b1;
          buf_index_q[n] <= req_index[4*n +: 4];
          buf_value_q[n] <= req_value[23*n +: 23];
        end else if (coalesce[n]) begin
          ack_q[n]       <= 1'b1;
          buf_value_q[n] <= req_value[23*n +: 23];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      out_index_q  <= VIDEO_NOP;
      out_value_q  <= '0;
      last_grant_q <= 2'd2;
      gap_cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_fire) begin
            out_index_q  <= buf_index_q[grant_idx];
            out_value_q  <= buf_value_q[grant_idx];
            last_grant_q <= grant_idx;
            state_q      <= ISSUE;
          end else begin
            out_index_q <= VIDEO_NOP;
            out_value_q <= '0;
          end
        end
        ISSUE: begin
          out_index_q <= VIDEO_NOP;
          out_value_q <= '0;
          if (MIN_GAP > 0) begin
            gap_cnt_q <= 4'(MIN_GAP - 1);
            state_q   <= GAP;
          end else begin
            state_q <= IDLE;
          end
        end
        GAP: begin
          out_index_q <= VIDEO_NOP;
          out_value_q <= '0;
          if (gap_cnt_q == 4'd0) begin
            state_q <= IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q - 4'd1;
          end
        end
        default: begin
          out_index_q <= VIDEO_NOP;
          out_value_q <= '0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign req_ack        = ack_q;
  assign pending        = full_q;
  assign register_index = out_index_q;
  assign register_value = out_value_q;
  assign dbg_state      = state_q;

endmodule

// File: doc/video_register_arbiter.md
VIDEO_REGISTER_ARBITER -- requirements
Module: video_register_arbiter

Interface
REQ-001 Parameter MIN_GAP, default 0: number of idle cycles (0..15) enforced after each issued register write.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  3  per-requester write request; requester n uses bit n (0 mouse, 1 cursor, 2 terminal).
REQ-005 req_index  input  12  requester n register index at [4n+3:4n].
REQ-006 req_value  input  69  requester n register value at [23n+22:23n].
REQ-007 req_ack  output  3  one-cycle pulse: requester n's request captured.
REQ-008 register_busy  input  1  video controller cannot take a write this cycle.
REQ-009 register_index  output  4  video register index; VIDEO_NOP when no write.
REQ-010 register_value  output  23  video register value; 0 when no write.
REQ-011 pending  output  3  bit n set while requester n's buffer holds an unissued write.

Function
REQ-012 Each requester SHALL own a one-entry buffer (index, value, full flag).
REQ-013 req_valid[n] sampled with buffer n empty and req_ack[n] low SHALL capture the index/value, set full, and pulse req_ack[n] the next cycle.
REQ-014 Requesters drop or change req_valid in the ack cycle; req_valid[n] during the req_ack[n] cycle SHALL be ignored.
REQ-015 State machine SHALL have states IDLE, ISSUE, GAP.
REQ-016 IDLE: with register_busy low and any buffer full, grant the first full buffer searching round-robin from last_grant+1 (mod 3). Drive its index/value on register_index/register_value (registered), clear its full flag, update last_grant, go to ISSUE.
REQ-017 IDLE with register_busy high or no buffer full: outputs VIDEO_NOP/0; stay in IDLE.
REQ-018 ISSUE SHALL last exactly one cycle with the write on the outputs. The next cycle returns outputs to VIDEO_NOP/0 and enters GAP if MIN_GAP>0, else IDLE.
REQ-019 GAP SHALL count MIN_GAP cycles with outputs VIDEO_NOP/0, then enter IDLE.
REQ-020 Minimum latency: request sampled cycle T, buffer full T+1, write on outputs T+2.
REQ-021 A request arriving in the same cycle its buffer is granted SHALL NOT be captured. It is captured no earlier than the following cycle.
REQ-022 Simultaneous requests from all three SHALL all be captured in the same cycle; issue order follows the round-robin pointer.
REQ-023 Back-to-back issues (MIN_GAP=0) SHALL be spaced 2 cycles (ISSUE, IDLE).
REQ-024 pending SHALL equal the buffer full flags.

Reset
REQ-025 Reset SHALL clear all buffers and set pending=0, req_ack=0, register_index=VIDEO_NOP, register_value=0, state=IDLE, gap counter=0, last_grant=2 (requester 0 first).
REQ-026 Reset mid-operation SHALL discard buffered and in-flight writes. No write appears on the outputs in the cycle after reset.

Configuration
REQ-027 With VIDEO_REG_ARB_COALESCE_EN defined, a request to a full, not-currently-granted buffer with equal index SHALL overwrite the buffered value and pulse req_ack.
REQ-028 With VIDEO_REG_ARB_COALESCE_EN defined, a different index to a full buffer SHALL wait, with no ack.
REQ-029 With VIDEO_REG_ARB_COALESCE_EN undefined, any request to a full buffer SHALL wait, with no ack.

Verification
REQ-030 Single write: req_valid=001, index 5, value 0x12345 at T -> req_ack=001 at T+1; register_index=5, register_value=0x12345 at T+2 only; VIDEO_NOP/0 at T+3.
REQ-031 Contention: req_valid=111 one cycle after reset, MIN_GAP=0 -> writes issued in order requester 0,1,2, two cycles apart; pending goes 111 to 110 to 100 to 000.
REQ-032 Busy stall: buffer 1 full, register_busy high 5 cycles -> no write during busy; write appears the cycle after busy falls; pending[1] stays 1 until then.
REQ-033 Coalescing (macro defined): mouse writes index 7 value 0x100, register_busy high, then index 7 value 0x200 -> both acked; one write, value 0x200. Macro undefined -> second request not acked until first issued; two writes in order.
REQ-034 Gap: MIN_GAP=3, two buffers full -> second write appears exactly 5 cycles after the first.
REQ-035 Reset mid-operation: reset during ISSUE with buffers 1 and 2 full -> outputs VIDEO_NOP/0 and pending=000 the cycle after reset; no later writes without new requests.
